// File: rtl/console_io_port.sv
// Platform-side responder for the CPU I/O port bus: console stdin/stdout FIFOs,
// interrupt mask/status, halt/exit-code capture and a free-running cycle counter.
module console_io_port #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [8:0]  io_port,
    input  logic [15:0] data_out,
    input  logic        data_out_valid,
    output logic [15:0] data_in,
    output logic        irq,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted,
    output logic [15:0] exit_code
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_CAP = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_CAP = (TX_AW+1)'(TX_DEPTH);

    localparam logic [8:0] PORT_HALT   = 9'd0;
    localparam logic [8:0] PORT_STDIN  = 9'd2;
    localparam logic [8:0] PORT_STDOUT = 9'd3;
    localparam logic [8:0] PORT_STATUS = 9'd4;
    localparam logic [8:0] PORT_MASK   = 9'd5;
    localparam logic [8:0] PORT_CYCLES = 9'd32;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_rd, rx_wr;
    logic [RX_AW:0]   rx_count;
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_rd, tx_wr;
    logic [TX_AW:0]   tx_count;

    logic [1:0]  mask;
    logic [15:0] cycle_count;

    logic rx_full, rx_empty, tx_full, tx_empty;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic [1:0] status;

    assign rx_full  = (rx_count == RX_CAP);
    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == TX_CAP);
    assign tx_empty = (tx_count == '0);

    // Fullness/emptiness come from the pre-cycle count, so a same-cycle pop never frees a slot.
    assign rx_push = rx_valid && !rx_full && !reset;
    assign rx_pop  = data_out_valid && (io_port == PORT_STDIN) && !rx_empty;
    assign tx_push = data_out_valid && (io_port == PORT_STDOUT) && !tx_full;
    assign tx_pop  = tx_ready && !tx_empty;

    assign rx_ready = !reset && !rx_full;
    assign tx_valid = !tx_empty;
    assign tx_byte  = tx_mem[tx_rd];
    assign status   = {!tx_full, !rx_empty} & mask;
    assign irq      = |status;

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr] <= rx_byte;
        if (tx_push) tx_mem[tx_wr] <= data_out[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_rd       <= '0;
            rx_wr       <= '0;
            rx_count    <= '0;
            tx_rd       <= '0;
            tx_wr       <= '0;
            tx_count    <= '0;
            mask        <= '0;
            halted      <= 1'b0;
            exit_code   <= '0;
            cycle_count <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + (RX_AW+1)'(1);
            else if (rx_pop && !rx_push) rx_count <= rx_count - (RX_AW+1)'(1);

            if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + (TX_AW+1)'(1);
            else if (tx_pop && !tx_push) tx_count <= tx_count - (TX_AW+1)'(1);

            if (data_out_valid && io_port == PORT_HALT) begin
                halted    <= 1'b1;
                exit_code <= data_out;
            end
            if (data_out_valid && io_port == PORT_MASK) mask <= data_out[1:0];

            if (data_out_valid && io_port == PORT_CYCLES) cycle_count <= '0;
            else                                          cycle_count <= cycle_count + 16'd1;
        end
    end

    always_comb begin
        data_in = '0;
        case (io_port)
            PORT_STDIN:  data_in = rx_empty ? 16'h8000 : {8'h00, rx_mem[rx_rd]};
            PORT_STDOUT: data_in = {15'b0, !tx_full};
            PORT_STATUS: data_in = {14'b0, status};
            PORT_MASK:   data_in = {14'b0, mask};
            PORT_CYCLES: data_in = cycle_count;
            default:     data_in = '0;
        endcase
    end

endmodule

// File: tb/tb_console_io_port.sv
// Randomised and directed bench for console_io_port, checked against a queue-based
// model of the port map, FIFOs, mask, halt register and cycle counter.
module tb_console_io_port;

    localparam int RX_DEPTH = 16;
    localparam int TX_DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  io_port;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [15:0] data_in;
    logic        irq;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;
    logic [15:0] exit_code;

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_rx[$];
    logic [7:0]  m_tx[$];
    logic [1:0]  m_mask;
    logic        m_halted;
    logic [15:0] m_exit;
    int          m_cycles;

    console_io_port #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
        .clock(clock), .reset(reset), .io_port(io_port), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_in(data_in), .irq(irq),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halted(halted), .exit_code(exit_code)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [8:0] port);
        logic [1:0] raw;
        raw = {m_tx.size() < TX_DEPTH, m_rx.size() != 0};
        case (port)
            9'd2:    return (m_rx.size() != 0) ? {8'h00, m_rx[0]} : 16'h8000;
            9'd3:    return (m_tx.size() < TX_DEPTH) ? 16'h0001 : 16'h0000;
            9'd4:    return {14'b0, raw & m_mask};
            9'd5:    return {14'b0, m_mask};
            9'd32:   return 16'(m_cycles);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_clear();
        m_rx.delete();
        m_tx.delete();
        m_mask   = 2'b00;
        m_halted = 1'b0;
        m_exit   = 16'h0000;
        m_cycles = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_tick();
        bit do_rx_push, do_rx_pop, do_tx_push, do_tx_pop;
        if (reset) begin
            model_clear();
            return;
        end
        do_rx_push = rx_valid && (m_rx.size() < RX_DEPTH);
        do_rx_pop  = data_out_valid && io_port == 9'd2 && m_rx.size() != 0;
        do_tx_push = data_out_valid && io_port == 9'd3 && m_tx.size() < TX_DEPTH;
        do_tx_pop  = tx_ready && m_tx.size() != 0;
        if (do_rx_pop)  void'(m_rx.pop_front());
        if (do_rx_push) m_rx.push_back(rx_byte);
        if (do_tx_pop)  void'(m_tx.pop_front());
        if (do_tx_push) m_tx.push_back(data_out[7:0]);
        if (data_out_valid && io_port == 9'd0) begin
            m_halted = 1'b1;
            m_exit   = data_out;
        end
        if (data_out_valid && io_port == 9'd5) m_mask = data_out[1:0];
        if (data_out_valid && io_port == 9'd32) m_cycles = 0;
        else m_cycles = (m_cycles + 1) % 65536;
    endtask

    task automatic compare_all();
        logic [1:0] raw;
        raw = {m_tx.size() < TX_DEPTH, m_rx.size() != 0};
        checkOutput("rx_ready", rx_ready, !reset && (m_rx.size() < RX_DEPTH));
        checkOutput("tx_valid", tx_valid, m_tx.size() != 0);
        if (m_tx.size() != 0) checkOutput("tx_byte", tx_byte, m_tx[0]);
        checkOutput("irq", irq, |(raw & m_mask));
        checkOutput("halted", halted, m_halted);
        checkOutput("exit_code", exit_code, m_exit);
        checkOutput($sformatf("data_in_port%0d", io_port), data_in, model_read(io_port));
    endtask

    // One bus cycle: drive inputs, check outputs mid-cycle, then let the clock edge happen.
    task automatic applyStimulus(input logic rst, input logic [8:0] port, input logic [15:0] dout,
                                 input logic dov, input logic [7:0] rxb, input logic rxv,
                                 input logic txr);
        reset = rst; io_port = port; data_out = dout; data_out_valid = dov;
        rx_byte = rxb; rx_valid = rxv; tx_ready = txr;
        #1;
        compare_all();
        model_tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic [8:0] port, input logic txr);
        applyStimulus(1'b0, port, 16'h0000, 1'b0, 8'h00, 1'b0, txr);
    endtask

    initial begin
        logic [8:0] port_list [8];
        port_list = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd32, 9'd100};

        reset = 1'b1; io_port = '0; data_out = '0; data_out_valid = 1'b0;
        rx_byte = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_clear();

        $display("[TB] reset and idle");
        applyStimulus(1'b1, 9'd32, 16'h0, 1'b0, 8'h55, 1'b1, 1'b0);
        applyStimulus(1'b1, 9'd2, 16'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(9'd2, 1'b0);
        idle(9'd3, 1'b0);
        idle(9'd32, 1'b0);
        checkOutput("cycles_after_idle", data_in, 16'h0003);

        $display("[TB] rx basic");
        applyStimulus(1'b0, 9'd5, 16'h0001, 1'b1, 8'h41, 1'b1, 1'b0);
        applyStimulus(1'b0, 9'd2, 16'h0000, 1'b0, 8'h42, 1'b1, 1'b0);
        checkOutput("rx_head_41", data_in, 16'h0041);
        applyStimulus(1'b0, 9'd2, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd2, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(9'd2, 1'b0);
        checkOutput("rx_empty_read", data_in, 16'h8000);

        $display("[TB] rx fill");
        for (int i = 0; i < RX_DEPTH + 2; i++)
            applyStimulus(1'b0, 9'd4, 16'h0, 1'b0, 8'($urandom), 1'b1, 1'b0);
        checkOutput("rx_full_ready", rx_ready, 1'b0);
        applyStimulus(1'b0, 9'd2, 16'h0, 1'b1, 8'hEE, 1'b1, 1'b0);
        idle(9'd2, 1'b0);
        checkOutput("rx_ready_after_pop", rx_ready, 1'b1);
        for (int i = 0; i < RX_DEPTH + 1; i++)
            applyStimulus(1'b0, 9'd2, 16'h0, 1'b1, 8'($urandom), ($urandom_range(0, 1) == 1), 1'b0);

        $display("[TB] tx fill and drain");
        applyStimulus(1'b0, 9'd5, 16'h0002, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < TX_DEPTH + 1; i++)
            applyStimulus(1'b0, 9'd3, 16'h1234, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(9'd3, 1'b0);
        checkOutput("tx_full_read", data_in, 16'h0000);
        checkOutput("irq_tx_full", irq, 1'b0);
        idle(9'd4, 1'b0);
        applyStimulus(1'b0, 9'd3, 16'h0077, 1'b1, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < TX_DEPTH + 2; i++) idle(9'd4, 1'b1);
        checkOutput("tx_drained", tx_valid, 1'b0);

        $display("[TB] halt and reset flush");
        applyStimulus(1'b0, 9'd3, 16'h00C3, 1'b1, 8'h19, 1'b1, 1'b0);
        applyStimulus(1'b0, 9'd0, 16'h00AA, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(9'd0, 1'b0);
        checkOutput("exit_code_aa", exit_code, 16'h00AA);
        applyStimulus(1'b0, 9'd0, 16'h0105, 1'b1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd2, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(9'd2, 1'b0);
        checkOutput("halted_cleared", halted, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            logic [8:0] port;
            port = port_list[$urandom_range(0, 7)];
            if (port == 9'd0 && $urandom_range(0, 9) != 0) port = 9'd4;
            applyStimulus($urandom_range(0, 199) == 0, port, 16'($urandom),
                          $urandom_range(0, 2) != 0, 8'($urandom),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/console_io_port.md
Name: console_io_port

Overview:
- Platform-side responder for the CPU I/O port bus (io_port / data_in / data_out / data_out_valid).
- Implements reserved ports 0, 2, 3, 4 and 5, plus platform port 32.
- Buffers stdin and stdout bytes in FIFOs toward a host byte stream.
- Generates the CPU irq line from pending-and-unmasked interrupt sources.

Parameters:
RX_DEPTH, 16, stdin FIFO depth in bytes; power of 2, >= 2
TX_DEPTH, 16, stdout FIFO depth in bytes; power of 2, >= 2

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
io_port  input  9  port number from CPU
data_out  input  16  CPU write data; meaningful only when data_out_valid=1
data_out_valid  input  1  CPU write strobe, 1 cycle per OUT
data_in  output  16  combinational read data for io_port
irq  output  1  interrupt request to CPU
rx_byte  input  8  host stdin byte
rx_valid  input  1  host offers rx_byte
rx_ready  output  1  stdin FIFO can accept; transfer when rx_valid&&rx_ready
tx_byte  output  8  stdout byte to host (head of TX FIFO)
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  host accepts; transfer when tx_valid&&tx_ready
halted  output  1  sticky; set by a write to port 0
exit_code  output  16  data written to port 0

Behaviour:
- Reset (synchronous, active-high):
  - Both FIFOs empty; mask=0, halted=0, exit_code=0, cycle counter=0.
  - Outputs during and after reset: rx_ready=0 while reset is high; tx_valid=0, irq=0.
  - Reset mid-transfer discards all buffered bytes.
- data_in is purely combinational from io_port and registered state. Reads have no side effects.
  - Port 2: {8'h00, RX head} if RX non-empty, else 16'h8000.
  - Port 3: 16'h0001 if TX not full, else 16'h0000.
  - Port 4: {14'b0, status}; status = raw & mask, raw = {tx_not_full, rx_not_empty}.
  - Port 5: {14'b0, mask}.
  - Port 32: free-running 16-bit cycle counter; wraps FFFF->0000.
  - All other ports, including 0 and 1: 16'h0000.
- Writes act only when data_out_valid=1:
  - Port 0: halted<=1, exit_code<=data_out. A later port 0 write updates exit_code; halted stays 1 until reset.
  - Port 1: ignored (owned by the CPU).
  - Port 2: pop RX head. Ignored if RX is empty.
  - Port 3: push data_out[7:0] to TX. Silently dropped if TX is full.
  - Port 4: ignored.
  - Port 5: mask <= data_out[1:0].
  - Port 32: counter <= 0 (the counter resumes incrementing the next cycle).
  - Any other port: ignored.
- RX FIFO:
  - rx_ready = !full, derived from registered count only.
  - A push while full cannot occur; a pop in the same cycle does not open a slot that cycle.
  - Simultaneous host push and CPU pop when non-empty and not full: count unchanged, order preserved.
  - A byte pushed in cycle N is readable on port 2 in cycle N+1.
- TX FIFO:
  - tx_valid = !empty; tx_byte = head, stable while tx_valid && !tx_ready.
  - A byte written in cycle N gives tx_valid=1 in cycle N+1 if the FIFO was empty.
  - Simultaneous CPU push and host pop when full: the push is dropped, because fullness is evaluated on pre-cycle count.
- irq = |status, from registered state only; asserts the cycle after the enabling event.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

Test Plan:
- Reset, then 3 idle cycles -> rx_ready=1, tx_valid=0, irq=0; port 2 reads 16'h8000, port 3 reads 16'h0001, port 32 reads 16'h0002.
- Host pushes 0x41 then 0x42; mask=1 -> irq=1 next cycle; port 2 reads 16'h0041. Write port 2 -> reads 16'h0042. Write port 2 -> reads 16'h8000, irq=0.
- Host pushes RX_DEPTH bytes with no pops -> rx_ready=0. A further rx_valid is not accepted. One port 2 pop -> rx_ready=1 next cycle.
- tx_ready=0; write port 3 with 0x1234 17 times (TX_DEPTH=16) -> port 3 reads 0 after the 16th. Then tx_ready=1 -> bytes 0x34 x16 drain in order, 17th absent.
- mask=2, TX not full -> irq=1. Fill TX -> irq=0. Port 4 reads 16'h0000 when full, 16'h0002 when not.
- Write port 0 with 0x00AA -> halted=1, exit_code=0x00AA next cycle. Assert reset -> halted=0, exit_code=0, FIFOs flushed.
